music_note_sequencer: RTL and testbench
=======================================

Name: music_note_sequencer

Overview:
Reader side of the song ROM. Walks the note ROM from address 0, fetches one 32-bit note word at a time, decodes pitch and duration, and holds the pitch on note_o for that many beat units. The downstream tone generator consumes note_o. Supports start/stop, looping and end-of-song detection, and is the sole master of the ROM's addr/en port.

Parameters:
ADDR_WIDTH, 16, ROM address width
DATA_WIDTH, 32, ROM word width (must be >= 16)
TICK_DIV, 6250000, clk cycles per beat unit (1/16 s at 100 MHz); must be >= 1
END_CODE, 8'hFF, pitch code marking end of song

Ports:
clk  in  1  system clock; the only clock
rst  in  1  reset, asynchronous and active-high
start_i  in  1  begin playback from address 0; level sampled, acted on in IDLE only
stop_i  in  1  abort playback; priority over start_i
loop_i  in  1  1 = restart at address 0 on end of song; sampled when end is detected
rom_addr_o  out  ADDR_WIDTH  ROM read address (registered)
rom_en_o  out  1  ROM read enable (registered), 1-cycle pulse per fetch
rom_data_i  in  DATA_WIDTH  ROM data, valid the cycle after rom_en_o
note_o  out  8  current pitch code; 0 = rest/silence
note_strobe_o  out  1  1-cycle pulse when note_o takes a new note
playing_o  out  1  1 while not in IDLE
done_o  out  1  1-cycle pulse at end of song when not looping

Behaviour:
- Word format: rom_data_i[15:8] = pitch code; rom_data_i[7:0] = duration in beat units; bits above 15 are ignored. Duration 0 is treated as 1.
- Reset (asynchronous, any state): state IDLE; rom_addr_o=0, rom_en_o=0, note_o=0, note_strobe_o=0, playing_o=0, done_o=0; all counters 0.
- FSM states: IDLE, FETCH, LATCH, PLAY.
- IDLE: outputs idle, note_o=0. start_i=1 and stop_i=0 at an edge moves to FETCH with rom_addr_o=0, rom_en_o=1.
- FETCH (1 cycle): rom_en_o=1 with rom_addr_o stable; the ROM registers data on this edge. Next state is LATCH, with rom_en_o=0.
- LATCH (1 cycle): rom_data_i is valid and captured.
  - Pitch == END_CODE, or the word came from the last address (2^ADDR_WIDTH-1) and was not END_CODE: treat as end of song (the last-address note is still played first, then ends).
  - End of song with loop_i=1: rom_addr_o=0, go to FETCH; note_o unchanged.
  - End of song with loop_i=0: note_o=0, done_o pulses 1 cycle, go to IDLE.
  - Otherwise: note_o <= pitch, note_strobe_o pulses, load beat counter = duration and tick counter = TICK_DIV-1, go to PLAY.
- PLAY: tick counter decrements each cycle. When it reaches 0 it reloads TICK_DIV-1 and the beat counter decrements. When the beat counter reaches 0 at a tick end, increment rom_addr_o and go to FETCH.
  - PLAY lasts exactly duration*TICK_DIV cycles.
- note_o holds the previous pitch through FETCH/LATCH between notes, so there is no glitch to 0.
- Latency: start sampled at edge E0; rom_en_o high E0..E1; note_o and note_strobe_o valid after E2.
  - Note-to-note period = duration*TICK_DIV + 2 cycles.
- stop_i=1 at any edge, any state: next state IDLE, note_o=0, rom_addr_o=0, rom_en_o=0, no done_o pulse.
  - stop_i and start_i both high in IDLE: remain in IDLE.
- start_i while playing: ignored; holding start_i high across end-of-song with loop_i=0 restarts on the cycle after IDLE is entered.
- playing_o = (state != IDLE), registered with the state.
- Arithmetic: the beat counter is 8 bits. The tick counter is wide enough for TICK_DIV-1. Address increment has no wrap, because the last address always ends the song.

Test Plan:
- Reset mid-PLAY: assert rst asynchronously between edges -> all outputs 0 immediately, state IDLE, no done_o.
- Basic playback (TICK_DIV=4, ROM {0x0000_0A02, 0x0000_0C01, 0x0000_FF00}, loop_i=0): start pulse -> rom_en_o at addr 0, 1, 2. note_o=0x0A for 8 cycles, then 0x0C appears after 2 more cycles and holds 4 cycles. done_o pulses once, then note_o=0 and playing_o=0. Exactly 2 strobes.
- Zero duration and rest (ROM {0x0000_0000, 0x0000_0500, 0x0000_FF00}): pitch 0 held 4 cycles and pitch 5 held 4 cycles (0 -> 1). Strobe on both notes.
- Loop: same ROM as basic playback with loop_i=1 -> after the END word, rom_addr_o returns to 0 and 0x0A replays. No done_o. Clearing loop_i before the second END -> done_o once.
- Stop priority: stop_i during PLAY of note 2 -> next cycle IDLE, note_o=0, rom_addr_o=0. start_i and stop_i high together in IDLE -> stays IDLE.
- Last-address end (ADDR_WIDTH=2, ROM {0x0101, 0x0201, 0x0301, 0x0401}, no END word): plays 1, 2, 3, 4, then done_o. rom_addr_o never exceeds 3.

Source files
------------

// File: rtl/music_note_sequencer.sv
// Song ROM reader: walks the note ROM from address 0 and decodes one word per note.
// Each word carries an 8-bit pitch and an 8-bit duration in beat units.
// The pitch is held on note_o for that many beats.
// Playback ends on the END_CODE pitch, or after the note at the last ROM address.
module music_note_sequencer #(
    parameter int              ADDR_WIDTH = 16,
    parameter int              DATA_WIDTH = 32,
    parameter int              TICK_DIV   = 6250000,
    parameter logic [7:0]      END_CODE   = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  loop_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    output logic                  rom_en_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    output logic [7:0]            note_o,
    output logic                  note_strobe_o,
    output logic                  playing_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {IDLE, FETCH, LATCH, PLAY} state_t;

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0]     TICK_RELOAD = TICK_W'(TICK_DIV - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic                  en_n;
    logic [7:0]            note_n;
    logic                  strobe_n;
    logic                  done_n;
    logic [7:0]            beat_cnt, beat_n;
    logic [TICK_W-1:0]     tick_cnt, tick_n;
    logic                  end_song;

    logic [7:0] word_pitch;
    logic [7:0] word_dur;

    assign word_pitch = rom_data_i[15:8];
    assign word_dur   = rom_data_i[7:0];

    // Bits above the pitch/duration fields carry nothing for this reader.
    generate
        if (DATA_WIDTH > 16) begin : g_unused
            logic unused_upper;
            assign unused_upper = ^rom_data_i[DATA_WIDTH-1:16];
        end
    endgenerate

    // Next-state and next-output decode; stop wins over everything, end of song either loops or finishes.
    always_comb begin
        state_n  = state;
        addr_n   = rom_addr_o;
        en_n     = 1'b0;
        note_n   = note_o;
        strobe_n = 1'b0;
        done_n   = 1'b0;
        beat_n   = beat_cnt;
        tick_n   = tick_cnt;
        end_song = 1'b0;

        if (stop_i) begin
            state_n = IDLE;
            addr_n  = '0;
            note_n  = '0;
            beat_n  = '0;
            tick_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    note_n = '0;
                    addr_n = '0;
                    if (start_i) begin
                        state_n = FETCH;
                        en_n    = 1'b1;
                    end
                end
                FETCH: begin
                    state_n = LATCH;
                end
                LATCH: begin
                    if (word_pitch == END_CODE) begin
                        end_song = 1'b1;
                    end else begin
                        note_n   = word_pitch;
                        strobe_n = 1'b1;
                        beat_n   = (word_dur == 8'd0) ? 8'd1 : word_dur;
                        tick_n   = TICK_RELOAD;
                        state_n  = PLAY;
                    end
                end
                PLAY: begin
                    if (tick_cnt == '0) begin
                        tick_n = TICK_RELOAD;
                        beat_n = beat_cnt - 8'd1;
                        if (beat_cnt == 8'd1) begin
                            if (rom_addr_o == LAST_ADDR) begin
                                end_song = 1'b1;
                            end else begin
                                addr_n  = rom_addr_o + ADDR_WIDTH'(1);
                                en_n    = 1'b1;
                                state_n = FETCH;
                            end
                        end
                    end else begin
                        tick_n = tick_cnt - TICK_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase

            if (end_song) begin
                addr_n = '0;
                if (loop_i) begin
                    en_n    = 1'b1;
                    state_n = FETCH;
                end else begin
                    note_n  = '0;
                    done_n  = 1'b1;
                    beat_n  = '0;
                    tick_n  = '0;
                    state_n = IDLE;
                end
            end
        end
    end

    // State, counters and all outputs are registered together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rom_addr_o    <= '0;
            rom_en_o      <= 1'b0;
            note_o        <= '0;
            note_strobe_o <= 1'b0;
            playing_o     <= 1'b0;
            done_o        <= 1'b0;
            beat_cnt      <= '0;
            tick_cnt      <= '0;
        end else begin
            state         <= state_n;
            rom_addr_o    <= addr_n;
            rom_en_o      <= en_n;
            note_o        <= note_n;
            note_strobe_o <= strobe_n;
            playing_o     <= (state_n != IDLE);
            done_o        <= done_n;
            beat_cnt      <= beat_n;
            tick_cnt      <= tick_n;
        end
    end

endmodule

// File: tb/tb_music_note_sequencer.sv
// Self-checking bench for music_note_sequencer.
// A song model walks the bench ROM and queues the expected fetch addresses.
// It also queues the expected note/done events with their cycle numbers.
// A per-cycle monitor pops and compares these against what the DUT produces.
module tb_music_note_sequencer;

    localparam int AW  = 2;
    localparam int DW  = 32;
    localparam int TDV = 4;

    logic          clk;
    logic          rst;
    logic          start_i;
    logic          stop_i;
    logic          loop_i;
    logic [AW-1:0] rom_addr_o;
    logic          rom_en_o;
    logic [DW-1:0] rom_data_i;
    logic [7:0]    note_o;
    logic          note_strobe_o;
    logic          playing_o;
    logic          done_o;

    typedef struct {
        bit         is_done;
        logic [7:0] note;
        int         rel;
    } ev_t;

    logic [31:0]   rom_mem [4];
    ev_t           evq[$];
    logic [AW-1:0] fq[$];

    int         vectors;
    int         miscompares;
    int         cyc;
    int         start_ref;
    int         events_seen;
    logic [7:0] model_note;
    logic       model_active;

    music_note_sequencer #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TICK_DIV  (TDV),
        .END_CODE  (8'hFF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .loop_i       (loop_i),
        .rom_addr_o   (rom_addr_o),
        .rom_en_o     (rom_en_o),
        .rom_data_i   (rom_data_i),
        .note_o       (note_o),
        .note_strobe_o(note_strobe_o),
        .playing_o    (playing_o),
        .done_o       (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data valid the cycle after the enable.
    always @(posedge clk) begin
        if (rom_en_o) rom_data_i <= rom_mem[rom_addr_o];
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic pushEv(input bit is_done, input logic [7:0] note, input int rel);
        ev_t e;
        e.is_done = is_done;
        e.note    = note;
        e.rel     = rel;
        evq.push_back(e);
    endtask

    // Walk the bench ROM the way the sequencer should, queuing fetches and events.
    task automatic queueSong(input int loops_before_end);
        int         t;
        int         addr;
        int         loops;
        int         dd;
        logic [7:0] p;
        logic [7:0] d;
        t     = 2;
        addr  = 0;
        loops = loops_before_end;
        for (int guard = 0; guard < 64; guard++) begin
            fq.push_back(AW'(addr));
            p = rom_mem[addr][15:8];
            d = rom_mem[addr][7:0];
            if (p == 8'hFF) begin
                if (loops > 0) begin
                    loops--;
                    addr = 0;
                    t += 2;
                end else begin
                    pushEv(1'b1, 8'h00, t);
                    break;
                end
            end else begin
                pushEv(1'b0, p, t);
                dd = (d == 8'd0) ? 1 : int'(d);
                t += dd * TDV;
                if (addr == 3) begin
                    if (loops > 0) begin
                        loops--;
                        addr = 0;
                        t += 2;
                    end else begin
                        pushEv(1'b1, 8'h00, t);
                        break;
                    end
                end else begin
                    addr++;
                    t += 2;
                end
            end
        end
    endtask

    // Per-cycle comparison of DUT activity against the queued expectations.
    task automatic monitorCycle();
        ev_t           e;
        logic [AW-1:0] a;
        if (rst) return;
        if (rom_en_o) begin
            if (fq.size() == 0) begin
                checkOutput("spurious_fetch", 32'(rom_en_o), 32'd0);
            end else begin
                a = fq.pop_front();
                checkOutput("fetch_addr", 32'(rom_addr_o), 32'(a));
            end
        end
        if (note_strobe_o || done_o) begin
            if (evq.size() == 0) begin
                checkOutput("spurious_event", 32'({note_strobe_o, done_o}), 32'd0);
            end else begin
                e = evq.pop_front();
                checkOutput("event_kind", 32'(done_o), 32'(e.is_done));
                checkOutput("event_cycle", 32'(cyc), 32'(start_ref + e.rel));
                if (e.is_done) begin
                    model_active = 1'b0;
                    model_note   = 8'h00;
                end else begin
                    model_note = e.note;
                end
                events_seen++;
            end
        end
        checkOutput("note_o", 32'(note_o), 32'(model_note));
        checkOutput("playing_o", 32'(playing_o), 32'(model_active));
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        monitorCycle();
    endtask

    task automatic loadRom(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3);
        rom_mem[0] = w0;
        rom_mem[1] = w1;
        rom_mem[2] = w2;
        rom_mem[3] = w3;
        events_seen = 0;
    endtask

    // One-cycle start pulse; the next edge is the reference for event timing.
    task automatic applyStimulus();
        start_i      = 1'b1;
        start_ref    = cyc + 1;
        model_active = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic waitEvents(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (events_seen < n && k < budget) begin
            tick();
            k++;
        end
        if (events_seen < n) checkOutput(tag, 32'(events_seen), 32'(n));
    endtask

    task automatic drainCheck(input string tag);
        repeat (3) tick();
        checkOutput({tag, "_events_left"}, 32'(evq.size()), 32'd0);
        checkOutput({tag, "_fetches_left"}, 32'(fq.size()), 32'd0);
        evq.delete();
        fq.delete();
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        cyc          = 0;
        start_ref    = 0;
        events_seen  = 0;
        model_note   = 8'h00;
        model_active = 1'b0;
        rst          = 1'b1;
        start_i      = 1'b0;
        stop_i       = 1'b0;
        loop_i       = 1'b0;
        rom_data_i   = '0;
        loadRom(32'h0, 32'h0, 32'h0, 32'h0);

        tick();
        checkOutput("reset_addr", 32'(rom_addr_o), 32'd0);
        checkOutput("reset_en", 32'(rom_en_o), 32'd0);
        checkOutput("reset_note", 32'(note_o), 32'd0);
        checkOutput("reset_strobe", 32'(note_strobe_o), 32'd0);
        checkOutput("reset_playing", 32'(playing_o), 32'd0);
        checkOutput("reset_done", 32'(done_o), 32'd0);
        rst = 1'b0;
        tick();

        $display("[TB] basic playback");
        loadRom(32'h0000_0A02, 32'h0000_0C01, 32'h0000_FF00, 32'h0000_0000);
        queueSong(0);
        applyStimulus();
        waitEvents("basic_timeout", 3, 100);
        drainCheck("basic");

        $display("[TB] zero duration and rest");
        loadRom(32'h0000_0000, 32'h0000_0500, 32'h0000_FF00, 32'h0000_0000);
        queueSong(0);
        applyStimulus();
        waitEvents("zero_timeout", 3, 100);
        drainCheck("zero");

        $display("[TB] looping");
        loadRom(32'h0000_0A02, 32'h0000_0C01, 32'h0000_FF00, 32'h0000_0000);
        loop_i = 1'b1;
        queueSong(1);
        applyStimulus();
        waitEvents("loop_replay_timeout", 3, 100);
        loop_i = 1'b0;
        waitEvents("loop_end_timeout", 5, 100);
        drainCheck("loop");

        $display("[TB] stop priority");
        loadRom(32'h0000_0A02, 32'h0000_0C01, 32'h0000_FF00, 32'h0000_0000);
        fq.push_back(AW'(0));
        fq.push_back(AW'(1));
        pushEv(1'b0, 8'h0A, 2);
        pushEv(1'b0, 8'h0C, 12);
        applyStimulus();
        waitEvents("stop_timeout", 2, 100);
        tick();
        stop_i       = 1'b1;
        model_active = 1'b0;
        model_note   = 8'h00;
        tick();
        stop_i = 1'b0;
        checkOutput("stop_addr", 32'(rom_addr_o), 32'd0);
        checkOutput("stop_done", 32'(done_o), 32'd0);
        drainCheck("stop");
        start_i = 1'b1;
        stop_i  = 1'b1;
        repeat (3) tick();
        checkOutput("start_stop_idle", 32'(playing_o), 32'd0);
        checkOutput("start_stop_en", 32'(rom_en_o), 32'd0);
        start_i = 1'b0;
        stop_i  = 1'b0;
        tick();

        $display("[TB] last-address end");
        loadRom(32'h0000_0101, 32'h0000_0201, 32'h0000_0301, 32'h0000_0401);
        queueSong(0);
        applyStimulus();
        waitEvents("last_timeout", 5, 100);
        drainCheck("last");

        $display("[TB] reset mid-play");
        loadRom(32'h0000_0A02, 32'h0000_0C01, 32'h0000_FF00, 32'h0000_0000);
        fq.push_back(AW'(0));
        pushEv(1'b0, 8'h0A, 2);
        applyStimulus();
        waitEvents("rst_timeout", 1, 100);
        repeat (2) tick();
        #7;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_note", 32'(note_o), 32'd0);
        checkOutput("async_rst_playing", 32'(playing_o), 32'd0);
        checkOutput("async_rst_addr", 32'(rom_addr_o), 32'd0);
        checkOutput("async_rst_en", 32'(rom_en_o), 32'd0);
        checkOutput("async_rst_done", 32'(done_o), 32'd0);
        model_active = 1'b0;
        model_note   = 8'h00;
        tick();
        rst = 1'b0;
        drainCheck("rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
